// File: rtl/ebpc_pkg.sv
// Shared EBPC constants and types: stream widths, ZNZ run field, decoder state and bit-buffer shift codes.
package ebpc_pkg;

    localparam int DATA_W = 8;
    localparam int ZRL_W  = 4;
    localparam int CNT_W  = 24;
    localparam int BUF_W  = DATA_W + ZRL_W;
    localparam int FILL_W = $clog2(BUF_W + 1);
    localparam int RUN_W  = ZRL_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ZERO = 2'd2
    } znz_dec_state_t;

    typedef enum logic [1:0] {
        SHIFT_NONE = 2'd0,
        SHIFT_ONE  = 2'd1,
        SHIFT_ZSYM = 2'd2
    } bitbuf_shift_t;

    // A zero symbol's field r encodes a run of r+1 zero words.
    function automatic logic [RUN_W-1:0] run_len(input logic [ZRL_W-1:0] r);
        return RUN_W'(r) + RUN_W'(1);
    endfunction

endpackage

// File: rtl/ebpc_znz_bitbuf.sv
// MSB-aligned ZNZ bit buffer: consumes 0, 1 or 1+ZRL_W head bits and appends a whole ZNZ word below the remaining bits.
module ebpc_znz_bitbuf
    import ebpc_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  bitbuf_shift_t       shift_i,
    input  logic                app_i,
    input  logic [DATA_W-1:0]   app_data_i,
    output logic                head_o,
    output logic [ZRL_W-1:0]    run_bits_o,
    output logic [FILL_W-1:0]   fill_o
);

    logic [BUF_W-1:0]  buf_r;
    logic [BUF_W-1:0]  shifted_s;
    logic [BUF_W-1:0]  app_ext_s;
    logic [FILL_W-1:0] fill_r;
    logic [FILL_W-1:0] fill_sh_s;

    // Consume head bits first; bits below the fill level are kept zero so the append can simply OR in.
    always_comb begin
        shifted_s = buf_r;
        fill_sh_s = fill_r;
        case (shift_i)
            SHIFT_ONE: begin
                shifted_s = {buf_r[BUF_W-2:0], 1'b0};
                fill_sh_s = fill_r - FILL_W'(1);
            end
            SHIFT_ZSYM: begin
                shifted_s = {buf_r[BUF_W-RUN_W-1:0], {RUN_W{1'b0}}};
                fill_sh_s = fill_r - FILL_W'(RUN_W);
            end
            default: begin
                shifted_s = buf_r;
                fill_sh_s = fill_r;
            end
        endcase
        app_ext_s = {app_data_i, {ZRL_W{1'b0}}} >> fill_sh_s;
    end

    // Buffer storage and fill level; flush discards stream padding.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_r  <= {BUF_W{1'b0}};
            fill_r <= {FILL_W{1'b0}};
        end else if (flush_i) begin
            buf_r  <= {BUF_W{1'b0}};
            fill_r <= {FILL_W{1'b0}};
        end else if (app_i) begin
            buf_r  <= shifted_s | app_ext_s;
            fill_r <= fill_sh_s + FILL_W'(DATA_W);
        end else begin
            buf_r  <= shifted_s;
            fill_r <= fill_sh_s;
        end
    end

    assign head_o     = buf_r[BUF_W-1];
    assign run_bits_o = buf_r[BUF_W-2 -: ZRL_W];
    assign fill_o     = fill_r;

endmodule

// File: rtl/ebpc_znz_decoder.sv
// ZNZ run-length decoder: merges zero runs and non-zero words into the final stream with last.
// Optional EBPC_ZNZ_DEC_ERR_EN adds a sticky err_o for truncated runs and zero-valued non-zero words.
module ebpc_znz_decoder
    import ebpc_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
`ifdef EBPC_ZNZ_DEC_ERR_EN
    output logic                err_o,
`endif
    input  logic [CNT_W-1:0]    num_words_i,
    input  logic [DATA_W-1:0]   znz_data_i,
    input  logic                znz_vld_i,
    output logic                znz_rdy_o,
    input  logic [DATA_W-1:0]   nz_data_i,
    input  logic                nz_vld_i,
    output logic                nz_rdy_o,
    output logic [DATA_W-1:0]   data_o,
    output logic                last_o,
    output logic                vld_o,
    input  logic                rdy_i
);

    znz_dec_state_t    state_r;
    logic [CNT_W-1:0]  remaining_r;
    logic [RUN_W-1:0]  zcnt_r;
    logic              started_r;
    logic              vld_r;
    logic              last_r;
    logic [DATA_W-1:0] data_r;

    logic              head_s;
    logic [ZRL_W-1:0]  run_bits_s;
    logic [FILL_W-1:0] fill_s;
    logic [RUN_W-1:0]  run_s;
    logic              out_free_s;
    logic              znz_rdy_s;
    logic              znz_acc_s;
    logic              one_rdy_s;
    logic              zsym_rdy_s;
    logic              final_s;
    logic              pop_s;
    logic              emit_s;
    logic              zsym_go_s;
    logic              flush_s;
    logic [DATA_W-1:0] emit_data_s;
    bitbuf_shift_t     shift_s;

    ebpc_znz_bitbuf u_bitbuf (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (flush_s),
        .shift_i    (shift_s),
        .app_i      (znz_acc_s),
        .app_data_i (znz_data_i),
        .head_o     (head_s),
        .run_bits_o (run_bits_s),
        .fill_o     (fill_s)
    );

    assign run_s      = run_len(run_bits_s);
    assign out_free_s = !vld_r || rdy_i;
    assign znz_rdy_s  = started_r && (fill_s <= FILL_W'(ZRL_W));
    assign znz_acc_s  = znz_vld_i && znz_rdy_s;
    assign one_rdy_s  = (state_r == RUN) && (fill_s >= FILL_W'(1)) && head_s;
    assign zsym_rdy_s = (state_r == RUN) && (fill_s >= FILL_W'(RUN_W)) && !head_s;
    assign final_s    = (remaining_r <= CNT_W'(1));

    // Decode decision; a zero symbol emits its first zero in the same cycle to keep one word per cycle.
    always_comb begin
        pop_s       = 1'b0;
        emit_s      = 1'b0;
        zsym_go_s   = 1'b0;
        emit_data_s = {DATA_W{1'b0}};
        shift_s     = SHIFT_NONE;
        case (state_r)
            RUN: begin
                if (out_free_s && one_rdy_s && nz_vld_i) begin
                    pop_s       = 1'b1;
                    emit_s      = 1'b1;
                    emit_data_s = nz_data_i;
                    shift_s     = SHIFT_ONE;
                end else if (out_free_s && zsym_rdy_s) begin
                    emit_s    = 1'b1;
                    zsym_go_s = 1'b1;
                    shift_s   = SHIFT_ZSYM;
                end else begin
                    emit_s = 1'b0;
                end
            end
            ZERO: begin
                if (out_free_s) begin
                    emit_s = 1'b1;
                end else begin
                    emit_s = 1'b0;
                end
            end
            default: begin
                emit_s = 1'b0;
            end
        endcase
        flush_s = emit_s && final_s;
    end

    // Control FSM, counters and the registered output slice.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= IDLE;
            remaining_r <= {CNT_W{1'b0}};
            zcnt_r      <= {RUN_W{1'b0}};
            started_r   <= 1'b0;
            vld_r       <= 1'b0;
            last_r      <= 1'b0;
            data_r      <= {DATA_W{1'b0}};
        end else begin
            started_r <= 1'b1;
            if (out_free_s) begin
                vld_r  <= emit_s;
                last_r <= emit_s && final_s;
                if (emit_s) begin
                    data_r <= emit_data_s;
                end
            end
            if ((state_r == IDLE) && znz_acc_s) begin
                remaining_r <= num_words_i;
            end else if (emit_s && (remaining_r != {CNT_W{1'b0}})) begin
                remaining_r <= remaining_r - CNT_W'(1);
            end
            case (state_r)
                IDLE: begin
                    if (znz_acc_s) begin
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    if (flush_s) begin
                        state_r <= IDLE;
                    end else if (zsym_go_s && (run_s != RUN_W'(1))) begin
                        zcnt_r  <= run_s - RUN_W'(1);
                        state_r <= ZERO;
                    end
                end
                ZERO: begin
                    if (emit_s) begin
                        zcnt_r <= zcnt_r - RUN_W'(1);
                        if (final_s || (zcnt_r == RUN_W'(1))) begin
                            state_r <= final_s ? IDLE : RUN;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifdef EBPC_ZNZ_DEC_ERR_EN
    logic err_r;

    // Sticky stream error, cleared when the next stream starts.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_r <= 1'b0;
        end else if ((state_r == IDLE) && znz_acc_s) begin
            err_r <= 1'b0;
        end else if (zsym_go_s && (CNT_W'(run_s) > remaining_r)) begin
            err_r <= 1'b1;
        end else if (pop_s && (nz_data_i == {DATA_W{1'b0}})) begin
            err_r <= 1'b1;
        end
    end

    assign err_o = err_r;
`endif

    assign znz_rdy_o = znz_rdy_s;
    assign nz_rdy_o  = pop_s;
    assign vld_o     = vld_r;
    assign last_o    = last_r;
    assign data_o    = data_r;

endmodule

// File: tb/tb_ebpc_znz_decoder.sv
// Directed bench for ebpc_znz_decoder; err_o checks are built in when EBPC_ZNZ_DEC_ERR_EN is defined.
module tb_ebpc_znz_decoder;
    import ebpc_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [CNT_W-1:0]  num_words = '0;
    logic [DATA_W-1:0] znz_data = '0;
    logic              znz_vld = 1'b0;
    logic              znz_rdy;
    logic [DATA_W-1:0] nz_data = '0;
    logic              nz_vld = 1'b0;
    logic              nz_rdy;
    logic [DATA_W-1:0] data;
    logic              last;
    logic              vld;
    logic              rdy = 1'b0;
`ifdef EBPC_ZNZ_DEC_ERR_EN
    logic              err;
`endif

    int total = 0;
    int bad = 0;
    logic [7:0] zq[$];
    logic [7:0] nq[$];
    logic [7:0] eq[$];
    int n_znz_acc, n_nz_pop, first_hs_cyc, first_vld_cyc;

    always #5 clk = ~clk;

    ebpc_znz_decoder dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
`ifdef EBPC_ZNZ_DEC_ERR_EN
        .err_o       (err),
`endif
        .num_words_i (num_words),
        .znz_data_i  (znz_data),
        .znz_vld_i   (znz_vld),
        .znz_rdy_o   (znz_rdy),
        .nz_data_i   (nz_data),
        .nz_vld_i    (nz_vld),
        .nz_rdy_o    (nz_rdy),
        .data_o      (data),
        .last_o      (last),
        .vld_o       (vld),
        .rdy_i       (rdy)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // mode 0: always ready, 1: rdy low 3 cycles at the 2nd word, 2: random waits/readiness
    task automatic run_stream(input string tag, input int num, input int mode, input int abort_at);
        int zi = 0, ni = 0, oi = 0, cyc = 0, zwait = 0, nwait = 0, stall = 0;
        bit z_hs = 0, n_hs = 0, o_hs = 0, done = 0;
        n_znz_acc = 0; n_nz_pop = 0; first_hs_cyc = -1; first_vld_cyc = -1;
        num_words = CNT_W'(num);
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (z_hs) begin
                zi++; n_znz_acc++;
                if (mode == 2) zwait = $urandom_range(0, 3);
            end
            if (n_hs) begin
                ni++; n_nz_pop++;
                if (mode == 2) nwait = $urandom_range(0, 3);
            end
            if (o_hs) begin
                oi++;
                if (oi == num || oi == abort_at) done = 1;
            end
            if (done) break;
            if (mode == 1 && oi == 1 && vld && stall < 3) begin
                stall++; rdy = 1'b0;
            end else if (mode == 2) rdy = ($urandom_range(0, 3) != 0);
            else rdy = 1'b1;
            if (zwait > 0) begin zwait--; znz_vld = 1'b0; end
            else if (zi < zq.size()) begin znz_vld = 1'b1; znz_data = zq[zi]; end
            else znz_vld = 1'b0;
            if (nwait > 0) begin nwait--; nz_vld = 1'b0; end
            else if (ni < nq.size()) begin nz_vld = 1'b1; nz_data = nq[ni]; end
            else nz_vld = 1'b0;
            #1;
            z_hs = znz_vld && znz_rdy;
            n_hs = nz_vld && nz_rdy;
            o_hs = vld && rdy;
            if (z_hs && first_hs_cyc < 0) first_hs_cyc = cyc;
            if (vld && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (vld) begin
                if (oi < num) begin
                    check({tag, "_data"}, 32'(data), 32'(eq[oi]));
                    check({tag, "_last"}, 32'(last), 32'(oi == num - 1));
                end else begin
                    check({tag, "_extra_word"}, 32'(1), 32'(0));
                end
            end
        end
        if (!done) check({tag, "_timeout"}, 32'(oi), 32'(num));
        znz_vld = 1'b0;
        nz_vld = 1'b0;
        rdy = 1'b1;
    endtask

    task automatic load_sc1();
        zq = '{8'b1000_1000};
        nq = '{8'hA5};
        eq = '{8'hA5, 8'h00, 8'h00, 8'h00};
    endtask

    task automatic load_sc2();
        zq = '{8'b0111_1100};
        nq = '{8'h3C};
        eq.delete();
        for (int i = 0; i < 16; i++) eq.push_back(8'h00);
        eq.push_back(8'h3C);
    endtask

    task automatic check_idle_after(input string tag, input int zc, input int nc);
        check({tag, "_znz_cnt"}, 32'(n_znz_acc), 32'(zc));
        check({tag, "_nz_cnt"}, 32'(n_nz_pop), 32'(nc));
        @(negedge clk);
        check({tag, "_vld_after"}, 32'(vld), 32'(0));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("rst_vld", 32'(vld), 32'(0));
        check("rst_last", 32'(last), 32'(0));
        check("rst_data", 32'(data), 32'(0));
        check("rst_znz_rdy", 32'(znz_rdy), 32'(0));
        check("rst_nz_rdy", 32'(nz_rdy), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_znz_rdy_low", 32'(znz_rdy), 32'(0));
        @(negedge clk);
        check("rel_znz_rdy_high", 32'(znz_rdy), 32'(1));

        load_sc1();
        run_stream("s1", 4, 0, 0);
        check("s1_latency", 32'(first_vld_cyc - first_hs_cyc), 32'(2));
        check_idle_after("s1", 1, 1);
`ifdef EBPC_ZNZ_DEC_ERR_EN
        check("s1_err", 32'(err), 32'(0));
`endif

        load_sc2();
        run_stream("s2", 17, 0, 0);
        check_idle_after("s2", 1, 1);

        zq = '{8'b1111_0000, 8'b0000_0000};
        nq = '{8'h01, 8'h02, 8'h03, 8'h04};
        eq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
        run_stream("s3", 5, 0, 0);
        check_idle_after("s3", 2, 4);

        load_sc1();
        run_stream("s4bp", 4, 1, 0);
        check_idle_after("s4bp", 1, 1);
        for (int r = 0; r < 4; r++) begin
            load_sc1();
            run_stream("s4rnd", 4, 2, 0);
            check_idle_after("s4rnd", 1, 1);
        end

        zq = '{8'b0001_1000};
        nq.delete();
        eq = '{8'h00, 8'h00};
        run_stream("s5", 2, 0, 0);
        check_idle_after("s5", 1, 0);
`ifdef EBPC_ZNZ_DEC_ERR_EN
        check("s5_err_set", 32'(err), 32'(1));
        load_sc1();
        run_stream("s5b", 4, 0, 0);
        check("s5_err_clr", 32'(err), 32'(0));
`endif

        load_sc2();
        run_stream("s6", 17, 0, 2);
        rst_n = 1'b0;
        #1;
        check("s6_vld", 32'(vld), 32'(0));
        check("s6_last", 32'(last), 32'(0));
        check("s6_data", 32'(data), 32'(0));
        check("s6_znz_rdy", 32'(znz_rdy), 32'(0));
        check("s6_nz_rdy", 32'(nz_rdy), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load_sc1();
        run_stream("s6re", 4, 0, 0);
        check_idle_after("s6re", 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ebpc_znz_decoder.md
# ebpc_znz_decoder

Zero/non-zero run-length decoder for the EBPC decompression path; the inverse of the ZNZ output of `ebpc_encoder`. It consumes the packed ZNZ bitstream and a stream of already-decoded non-zero words (from the BPC decoder), and emits the reconstructed word stream: zeros where the ZNZ symbols say zero, and the next non-zero word otherwise. It sits at the output of the EBPC decoder top and drives the final data stream with `last`.

## Interface
- `DATA_W`, from `ebpc_pkg`: word width of all data streams.
- `ZRL_W`, from `ebpc_pkg` (4): run-length field width; maximum zero run is 2^ZRL_W.
- `CNT_W`, 24: width of the word counter.

Ports:
- `clk_i`  in  1  clock
- `rst_ni`  in  1  asynchronous active-low reset
- `num_words_i`  in  CNT_W  words in the stream (≥1); sampled when the first ZNZ word of a stream is accepted
- `znz_data_i`  in  DATA_W  packed ZNZ bits, MSB first
- `znz_vld_i`  in  1  ZNZ word valid
- `znz_rdy_o`  out  1  ZNZ word accepted
- `nz_data_i`  in  DATA_W  next non-zero word
- `nz_vld_i`  in  1  non-zero word valid
- `nz_rdy_o`  out  1  non-zero word accepted
- `data_o`  out  DATA_W  reconstructed word
- `last_o`  out  1  final word of the stream
- `vld_o`  out  1  output valid
- `rdy_i`  in  1  downstream ready

## Operation
- Symbols (MSB first, may straddle ZNZ word boundaries): `1` = one non-zero word; `0` + ZRL_W bits r = (r+1) zero words.
- Bit buffer of DATA_W+ZRL_W bits with fill counter. A ZNZ word is accepted (`znz_rdy_o`=1) when state≠IDLE-pending-reset and fill ≤ ZRL_W; new bits are appended below the existing ones.
- A symbol is decodable when fill≥1 and head=`1`, or fill≥1+ZRL_W and head=`0`.
- States:
  - IDLE: `znz_rdy_o`=1. On acceptance, latch `num_words_i` into the remaining counter → RUN.
  - RUN: decode the head symbol when the output register is free or being drained.
    - `1`: requires `nz_vld_i`; pops one nz word (`nz_rdy_o`=1 that cycle) into `data_o`.
    - `0`: loads the zero counter → ZERO.
  - ZERO: emit one zero word per free output slot until the counter expires → RUN.
- Each emitted word decrements remaining. On the final word, set `last_o` and flush the bit buffer (padding is discarded) → IDLE.
- A zero run longer than remaining is truncated at remaining.
- Arithmetic: the run counter is ZRL_W+1 bits wide; the remaining counter is CNT_W bits, unsigned, and never wraps.

## Timing
- Reset values: `vld_o`=0, `last_o`=0, `data_o`=0, `znz_rdy_o`=0, `nz_rdy_o`=0. The buffer is empty, state=IDLE, and all counters are 0.
- `znz_rdy_o` rises in the first cycle after reset release.
- Output is a registered valid/ready slice. While `vld_o`&&!`rdy_i`, `data_o` and `last_o` hold stable and nothing is popped.
- Latency: if the first ZNZ handshake completes in cycle k, `vld_o` is high in cycle k+2.
- Throughput: one word per cycle when the inputs are available and `rdy_i`=1. A refill happening in the same cycle as a decode causes no bubble.
- If a `1` symbol is pending and `nz_vld_i`=0, the block stalls with no output.
- A ZNZ word accepted in the same cycle as the final output word is discarded.
- Reset mid-stream aborts immediately. No partial word is emitted after reset.

## Configuration
- `EBPC_ZNZ_DEC_ERR_EN`: adds output `err_o` (1 bit, reset 0, sticky, cleared on the next IDLE→RUN).
  - Set if a zero run exceeds remaining.
  - Set if a popped non-zero word equals 0.
  - Data behaviour is unchanged.
- Without the macro: no `err_o` port, and truncation is silent.

## Structure
- `ebpc_pkg` holds `ZRL_W` and the `znz_dec_state_t` enum (IDLE, RUN, ZERO).
- One sub-module, `ebpc_znz_bitbuf`, which owns buffer storage, fill count, append and head-shift-by-1/1+ZRL_W.

## Test plan
(All scenarios use DATA_W=8, ZRL_W=4.)
1. Basic: num_words=4, ZNZ 8'b1000_1000, nz A5 → A5,00,00,00; `last_o` on the 4th word; nz popped once.
2. Max run: num_words=17, ZNZ 8'b0111_1100, nz 3C → 16×00 then 3C with last.
3. Straddle: num_words=5, ZNZ 8'b1111_0000 then 8'b0000_0000, nz 01..04 → 01,02,03,04,00 with last; both ZNZ words accepted.
4. Backpressure: scenario 1 with `rdy_i` low 3 cycles at the 2nd word → `data_o`/`last_o` stable during the stall; same sequence; random input waits 0–3 cycles give the same result.
5. Truncation with `EBPC_ZNZ_DEC_ERR_EN`: num_words=2, ZNZ 8'b0001_1000 (run 4) → 00,00 with last, `err_o`=1; the next stream clears it.
6. Reset: assert `rst_ni` after 2 outputs of scenario 2 → all outputs 0 next cycle; rerunning scenario 1 decodes correctly.
